// File: rtl/uart_fifo.sv
// TX and RX byte FIFOs between the CPU bus and the uart, each with a small handshake FSM.
// Optional UART_FIFO_OVERRUN_EN adds a sticky rx_overrun flag with overrun_clear.
module uart_fifo #(
  parameter int unsigned DEPTH_LOG2 = 4
) (
  input  logic                  raw_clk,
  input  logic                  reset_n,
  input  logic [7:0]            wr_data,
  input  logic                  wr_strobe,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [7:0]            rd_data,
  input  logic                  rd_strobe,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic [7:0]            uart_tx_data,
  output logic                  uart_tx_strobe,
  input  logic                  uart_tx_busy,
  input  logic [7:0]            uart_rx_data,
  input  logic                  uart_rx_ready,
  output logic                  uart_rx_ready_clear
`ifdef UART_FIFO_OVERRUN_EN
  ,
  output logic                  rx_overrun,
  input  logic                  overrun_clear
`endif
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = DEPTH_LOG2 + 1;
  localparam int unsigned PtrW  = DEPTH_LOG2;

  typedef enum logic {TxIdle, TxWait} tx_state_e;
  typedef enum logic {RxIdle, RxClear} rx_state_e;

  // TX FIFO
  logic [7:0]      tx_mem [Depth];
  logic [PtrW-1:0] tx_wr_ptr_q, tx_rd_ptr_q;
  logic [CntW-1:0] tx_count_q, tx_count_d;
  logic            tx_push, tx_pop;
  tx_state_e       tx_state_q, tx_state_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_strobe_q, tx_strobe_d;

  // RX FIFO
  logic [7:0]      rx_mem [Depth];
  logic [PtrW-1:0] rx_wr_ptr_q, rx_rd_ptr_q;
  logic [CntW-1:0] rx_count_q, rx_count_d;
  logic            rx_push_req, rx_push, rx_pop;
  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_clear_q, rx_clear_d;
  logic            rx_full;

  assign tx_full        = (tx_count_q == CntW'(Depth));
  assign tx_count       = tx_count_q;
  assign uart_tx_data   = tx_data_q;
  assign uart_tx_strobe = tx_strobe_q;

  assign rx_full             = (rx_count_q == CntW'(Depth));
  assign rx_empty            = (rx_count_q == '0);
  assign rx_count            = rx_count_q;
  assign rd_data             = rx_mem[rx_rd_ptr_q];
  assign uart_rx_ready_clear = rx_clear_q;

  always_comb begin
    tx_state_d  = tx_state_q;
    tx_data_d   = tx_data_q;
    tx_strobe_d = 1'b0;
    tx_pop      = 1'b0;
    unique case (tx_state_q)
      TxIdle: begin
        if (tx_count_q != '0 && !uart_tx_busy) begin
          tx_pop      = 1'b1;
          tx_strobe_d = 1'b1;
          tx_data_d   = tx_mem[tx_rd_ptr_q];
          tx_state_d  = TxWait;
        end
      end
      // uart raises tx_busy one cycle after the strobe; skip that cycle
      TxWait: tx_state_d = TxIdle;
      default: tx_state_d = TxIdle;
    endcase
  end

  // A full FIFO still accepts a push when a pop frees a slot that cycle
  assign tx_push = wr_strobe && (!tx_full || tx_pop);

  always_comb begin
    tx_count_d = tx_count_q;
    if (tx_push && !tx_pop)      tx_count_d = tx_count_q + CntW'(1);
    else if (!tx_push && tx_pop) tx_count_d = tx_count_q - CntW'(1);
  end

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_clear_d  = 1'b0;
    rx_push_req = 1'b0;
    unique case (rx_state_q)
      RxIdle: begin
        if (uart_rx_ready) begin
          rx_push_req = 1'b1;
          rx_clear_d  = 1'b1;
          rx_state_d  = RxClear;
        end
      end
      // gives the uart a cycle to drop rx_ready before we look again
      RxClear: rx_state_d = RxIdle;
      default: rx_state_d = RxIdle;
    endcase
  end

  assign rx_pop  = rd_strobe && !rx_empty;
  assign rx_push = rx_push_req && (!rx_full || rx_pop);

  always_comb begin
    rx_count_d = rx_count_q;
    if (rx_push && !rx_pop)      rx_count_d = rx_count_q + CntW'(1);
    else if (!rx_push && rx_pop) rx_count_d = rx_count_q - CntW'(1);
  end

  always_ff @(posedge raw_clk) begin
    if (tx_push) tx_mem[tx_wr_ptr_q] <= wr_data;
    if (rx_push) rx_mem[rx_wr_ptr_q] <= uart_rx_data;
  end

  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      tx_state_q  <= TxIdle;
      tx_data_q   <= '0;
      tx_strobe_q <= 1'b0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      rx_state_q  <= RxIdle;
      rx_clear_q  <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr_q <= tx_wr_ptr_q + PtrW'(1);
      if (tx_pop)  tx_rd_ptr_q <= tx_rd_ptr_q + PtrW'(1);
      tx_count_q  <= tx_count_d;
      tx_state_q  <= tx_state_d;
      tx_data_q   <= tx_data_d;
      tx_strobe_q <= tx_strobe_d;
      if (rx_push) rx_wr_ptr_q <= rx_wr_ptr_q + PtrW'(1);
      if (rx_pop)  rx_rd_ptr_q <= rx_rd_ptr_q + PtrW'(1);
      rx_count_q  <= rx_count_d;
      rx_state_q  <= rx_state_d;
      rx_clear_q  <= rx_clear_d;
    end
  end

`ifdef UART_FIFO_OVERRUN_EN
  logic rx_drop;
  logic rx_overrun_q;

  assign rx_drop    = rx_push_req && !rx_push;
  assign rx_overrun = rx_overrun_q;

  // set beats clear when both land in the same cycle
  always_ff @(posedge raw_clk or negedge reset_n) begin
    if (!reset_n)           rx_overrun_q <= 1'b0;
    else if (rx_drop)       rx_overrun_q <= 1'b1;
    else if (overrun_clear) rx_overrun_q <= 1'b0;
  end
`endif

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Byte-buffering stage between the CPU peripheral bus and the uart module.
- TX side: queues CPU-written bytes and drives uart tx_data/tx_strobe whenever uart tx_busy is low.
- RX side: drains uart rx_data/rx_ready into a queue the CPU pops at its own pace.
- Lets software burst up to 2**DEPTH_LOG2 bytes without polling per byte.

Parameters:
- DEPTH_LOG2, 4, log2 of entries per FIFO (16 TX + 16 RX); legal range 1..8.

Ports:
- raw_clk  input  1  system clock, same domain as uart
- reset_n  input  1  asynchronous active-low reset
- wr_data  input  8  CPU byte to transmit
- wr_strobe  input  1  one-cycle push of wr_data into TX FIFO
- tx_full  output  1  TX FIFO holds 2**DEPTH_LOG2 bytes
- tx_count  output  DEPTH_LOG2+1  TX FIFO occupancy
- rd_data  output  8  head of RX FIFO (first-word fall-through)
- rd_strobe  input  1  one-cycle pop of RX FIFO head
- rx_empty  output  1  RX FIFO holds 0 bytes
- rx_count  output  DEPTH_LOG2+1  RX FIFO occupancy
- uart_tx_data  output  8  to uart tx_data
- uart_tx_strobe  output  1  to uart tx_strobe
- uart_tx_busy  input  1  from uart tx_busy
- uart_rx_data  input  8  from uart rx_data
- uart_rx_ready  input  1  from uart rx_ready (level, sticky until cleared)
- uart_rx_ready_clear  output  1  to uart rx_ready_clear

Behaviour:
- Reset (reset_n low, async): pointers and counts 0; tx_full 0, rx_empty 1; uart_tx_strobe 0, uart_rx_ready_clear 0, uart_tx_data 0; both FSMs to IDLE. Memory contents not reset. Reset mid-frame discards queued bytes; a byte already strobed into uart completes on the wire.
- Each FIFO: circular buffer, DEPTH_LOG2-bit pointers wrapping 2**DEPTH_LOG2-1 -> 0; count tracked separately.
- wr_strobe while tx_full: byte dropped, no state change. rd_strobe while rx_empty: ignored.
- Push and pop in the same cycle on either FIFO: both happen; count unchanged. On a full FIFO, a push is still accepted when a pop occurs that cycle. On an empty FIFO, a pop is not permitted, even with a push that cycle.
- rd_data = mem[rd_ptr] combinationally. Valid only when rx_empty is 0.
- TX FSM:
  - TX_IDLE: if TX FIFO non-empty and uart_tx_busy == 0 -> load uart_tx_data with head, pop, assert uart_tx_strobe for exactly 1 cycle, go TX_WAIT.
  - TX_WAIT: lasts 1 cycle, because uart tx_busy rises one cycle after the strobe. Then -> TX_IDLE.
  - uart_tx_data is held stable from the strobe cycle until the next strobe.
  - Back-to-back bytes: next strobe no earlier than first cycle tx_busy reads 0 after TX_WAIT.
- RX FSM:
  - RX_IDLE: if uart_rx_ready == 1 -> push uart_rx_data (if not full), assert uart_rx_ready_clear for exactly 1 cycle, go RX_CLEAR.
  - RX_CLEAR: lasts 1 cycle, to let the uart flag drop. Then -> RX_IDLE.
  - RX FIFO full on arrival: byte discarded; clear still issued.
- CPU pop and FSM push on the same RX cycle follow the simultaneous rule above. The same applies to CPU push and FSM pop on TX.
- Latency:
  - wr_strobe on an empty TX FIFO with the uart idle -> uart_tx_strobe 2 cycles later (cycle 1: write; cycle 2: FSM sees non-empty, strobes registered).
  - uart_rx_ready rise -> rx_empty falls 1 cycle later.

Optional Feature:
- Macro UART_FIFO_OVERRUN_EN.
- Defined:
  - Adds output rx_overrun (1 bit) and input overrun_clear (1 bit).
  - rx_overrun is set on the cycle a received byte is dropped because the RX FIFO is full, and stays set until an overrun_clear pulse.
  - Set wins if it coincides with overrun_clear.
  - rx_overrun resets to 0.
- Undefined: the ports are absent and dropped bytes are silent.

Test Plan:
- Single TX:
  - Stimulus: reset, wr_data=0x41 with wr_strobe; uart model busy for 20 cycles after each strobe.
  - Response: uart_tx_strobe pulses once, 2 cycles after the write, with uart_tx_data=0x41; tx_count returns 0.
- TX burst/full (DEPTH_LOG2=4):
  - Stimulus: 17 consecutive writes 0x00..0x10 with uart held busy.
  - Response: tx_full=1 after the 16th write, 0x10 dropped, tx_count=16. After releasing busy, bytes 0x00..0x0F emerge in order, one strobe per busy-low window, never two strobes within 2 cycles.
- RX path:
  - Stimulus: model raises uart_rx_ready with data 0x5A, then 0xA5.
  - Response: uart_rx_ready_clear pulses once per byte; rd_data=0x5A with rx_count=2; after rd_strobe, rd_data=0xA5; after a second rd_strobe, rx_empty=1.
- RX overflow:
  - Stimulus: 17 received bytes with no CPU reads.
  - Response: first 16 retained, 17th dropped and still cleared. With UART_FIFO_OVERRUN_EN, rx_overrun=1 until overrun_clear.
- Simultaneous/wrap:
  - Stimulus: hold RX at count 16 and do a rd_strobe in the same cycle as an incoming byte; run 40 bytes total through each FIFO.
  - Response: count stays 16 with no drop, and pointers wrap with data order intact.
- Async reset:
  - Stimulus: reset_n asserted mid-burst with both FIFOs partly full.
  - Response: outputs return to reset values immediately (without waiting for a raw_clk edge), counts 0, no further uart_tx_strobe until a new write.
